// File: rtl/regfile_pkg.sv
// Shared definitions for the register bank with pending scoreboard.
//   clog2          : ceiling log2 constant function used to size addresses/counters
//   DEFAULT_WIDTH  : default bits per register
//   DEFAULT_DEPTH  : default number of registers
//   ZERO_REG       : index of the hardwired-zero entry
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;
  localparam int ZERO_REG      = 0;

  // Smallest n such that 2**n >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage : regfile_pkg

// File: rtl/reg_bank_sb_word.sv
// Single storage word of the register bank.
//   clk   : rising-edge clock
//   reset : synchronous active-high clear
//   en    : load d on the next edge
//   d     : data to load
//   q     : stored word
module reg_word
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] word_d;
  logic [WIDTH-1:0] word_q;

  // Load new data when enabled, otherwise hold.
  always_comb begin
    word_d = word_q;
    if (en) begin
      word_d = d;
    end else begin
      word_d = word_q;
    end
  end

  // Word storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign q = word_q;

endmodule : reg_word

// File: rtl/reg_bank_sb.sv
// Register bank with a per-entry pending scoreboard.
// Entry 0 is hardwired zero; addresses that are zero or >= DEPTH read as 0,
// never report busy, and are ignored by writeback and issue.
//   clk, reset             : clock and synchronous active-high reset
//   wr_en/wr_addr/wr_data  : writeback port; clears the entry's pending bit
//   rd_addr_a/rd_data_a    : combinational read port A (write-through bypass)
//   rd_addr_b/rd_data_b    : combinational read port B (write-through bypass)
//   busy_a/busy_b          : read entry still awaits its writeback
//   issue_en/issue_addr    : mark a destination pending
//   issue_ready            : destination has no outstanding writeback
//   pending_count          : registered number of pending entries
module reg_bank_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = clog2(DEPTH),
  parameter int CNT_W  = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_ready,
  output logic [CNT_W-1:0]  pending_count
);

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  // Nonzero and inside the populated range. The extra MSB keeps the
  // comparison meaningful when DEPTH is a power of two.
  function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
    return (addr != ZERO_ADDR) && ({1'b0, addr} < DEPTH_EXT);
  endfunction

  // Pending bit lookup that never indexes past DEPTH-1; invalid addresses
  // simply match no entry and report 0.
  function automatic logic pend_at(input logic [DEPTH-1:0]  vec,
                                   input logic [ADDR_W-1:0] addr);
    logic hit;
    hit = 1'b0;
    for (int i = 32'sd1; i < DEPTH; i++) begin
      hit = (addr == ADDR_W'(i)) ? vec[i] : hit;
    end
    return hit;
  endfunction

  logic [WIDTH-1:0] words_s [DEPTH];
  logic             wr_hit_s;
  logic             issue_ready_s;
  logic             issue_acc_s;
  logic [DEPTH-1:0] wr_sel_s;
  logic [DEPTH-1:0] issue_sel_s;
  logic             cnt_inc_s;
  logic             cnt_dec_s;
  logic [WIDTH-1:0] rd_data_a_s;
  logic [WIDTH-1:0] rd_data_b_s;
  logic [DEPTH-1:0] pending_d;
  logic [DEPTH-1:0] pending_q;
  logic [CNT_W-1:0] pending_count_d;
  logic [CNT_W-1:0] pending_count_q;

  assign words_s[0] = '0;
  assign wr_hit_s   = wr_en && addr_valid(wr_addr);

  // A writeback in the same cycle releases the destination, so a waiting
  // re-issue can go ahead without a bubble.
  assign issue_ready_s = !pend_at(pending_q, issue_addr) ||
                         (wr_en && (wr_addr == issue_addr));
  assign issue_acc_s   = issue_en && issue_ready_s;

  // One-hot decode of the writeback target and the accepted issue target.
  always_comb begin
    wr_sel_s    = '0;
    issue_sel_s = '0;
    for (int i = 32'sd1; i < DEPTH; i++) begin
      wr_sel_s[i]    = wr_hit_s && (wr_addr == ADDR_W'(i));
      issue_sel_s[i] = issue_acc_s && (issue_addr == ADDR_W'(i));
    end
  end

  for (genvar g = 1; g < DEPTH; g++) begin : g_word
    reg_word #(
      .WIDTH (WIDTH)
    ) u_word (
      .clk   (clk),
      .reset (reset),
      .en    (wr_sel_s[g]),
      .d     (wr_data),
      .q     (words_s[g])
    );
  end

  // Read muxes with write-through bypass of the writeback data.
  always_comb begin
    rd_data_a_s = '0;
    rd_data_b_s = '0;
    for (int i = 32'sd1; i < DEPTH; i++) begin
      rd_data_a_s = (rd_addr_a == ADDR_W'(i)) ?
                    (wr_sel_s[i] ? wr_data : words_s[i]) : rd_data_a_s;
      rd_data_b_s = (rd_addr_b == ADDR_W'(i)) ?
                    (wr_sel_s[i] ? wr_data : words_s[i]) : rd_data_b_s;
    end
  end

  assign rd_data_a = rd_data_a_s;
  assign rd_data_b = rd_data_b_s;

  // A same-cycle writeback satisfies the operand.
  assign busy_a = pend_at(pending_q, rd_addr_a) && !(wr_en && (wr_addr == rd_addr_a));
  assign busy_b = pend_at(pending_q, rd_addr_b) && !(wr_en && (wr_addr == rd_addr_b));

  assign issue_ready   = issue_ready_s;
  assign pending_count = pending_count_q;

  // Scoreboard next state: writeback clears, accepted issue sets, and the
  // set wins on a collision. The counter only moves on real bit flips.
  always_comb begin
    pending_d       = (pending_q & ~wr_sel_s) | issue_sel_s;
    pending_d[0]    = 1'b0;
    cnt_inc_s       = |(issue_sel_s & ~pending_q);
    cnt_dec_s       = |(wr_sel_s & pending_q & ~issue_sel_s);
    pending_count_d = pending_count_q + CNT_W'(cnt_inc_s) - CNT_W'(cnt_dec_s);
  end

  // Scoreboard and counter registers; reset overrides any same-cycle traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q       <= '0;
      pending_count_q <= '0;
    end else begin
      pending_q       <= pending_d;
      pending_count_q <= pending_count_d;
    end
  end

endmodule : reg_bank_sb
